// File: rtl/result_code_sink.sv
// result_code_sink
//   Downstream stage for the 4-bit nested-decision result code. It accepts one
//   code per cycle, classifies it, and buffers it in a small FIFO for the
//   consumer. It also keeps saturating per-class hit counters that are read
//   through a registered select port.
//
// Parameters
//   DEPTH  FIFO entries (power of two, >= 2)
//   CNT_W  width of each class hit counter
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake, in_result = code from decoder
//   out_valid/out_ready downstream handshake, out_result/out_class = FIFO head
//   cnt_clear           synchronous clear of all counters and err_sticky
//   cnt_sel/cnt_value   class counter select, registered counter value
//   err_sticky          an illegal code was accepted since reset/clear
//
// Configuration
//   RESULT_SINK_DROP_ILLEGAL_EN  when defined, illegal codes (class 7) are
//                                counted but are not written to the FIFO.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. ready never depends on valid. in_ready is purely occupancy-based,
// so a full FIFO refuses input even while the head is being popped.
module result_code_sink #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_result,
    output logic [2:0]       out_class,
    input  logic             cnt_clear,
    input  logic [2:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_value,
    output logic             err_sticky
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [2:0] classify(input logic [3:0] code);
        logic [2:0] cls;
        case (code)
            4'b1111: cls = 3'd0;
            4'b0000: cls = 3'd1;
            4'b0001: cls = 3'd2;
            4'b0011: cls = 3'd3;
            4'b0010: cls = 3'd4;
            4'b0100: cls = 3'd5;
            4'b1000: cls = 3'd6;
            default: cls = 3'd7;
        endcase
        return cls;
    endfunction

    logic [3:0]       mem_q [DEPTH];
    logic [3:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] cnt_q [8];
    logic [CNT_W-1:0] cnt_d [8];
    logic [CNT_W-1:0] cnt_value_q, cnt_value_d;
    logic             err_q, err_d;

    logic       accept;
    logic       wr_en;
    logic       rd_en;
    logic [2:0] in_class;
    logic [CNT_W-1:0] cnt_base;

    assign in_ready   = (occ_q < OCC_W'(DEPTH));
    assign out_valid  = (occ_q != '0);
    assign out_result = out_valid ? mem_q[rd_ptr_q] : 4'b0000;
    assign out_class  = out_valid ? classify(mem_q[rd_ptr_q]) : 3'd0;
    assign cnt_value  = cnt_value_q;
    assign err_sticky = err_q;

    assign in_class = classify(in_result);
    assign accept   = in_valid && in_ready;
    assign rd_en    = out_valid && out_ready;
`ifdef RESULT_SINK_DROP_ILLEGAL_EN
    // Illegal codes are metered but never reach the consumer.
    assign wr_en    = accept && (in_class != 3'd7);
`else
    assign wr_en    = accept;
`endif

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = in_result;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (wr_en && !rd_en) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!wr_en && rd_en) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    // Clear takes effect before a same-cycle accept, so the accepted code is
    // counted from zero and may immediately re-set err_sticky.
    always_comb begin
        cnt_d       = cnt_q;
        err_d       = err_q;
        cnt_base    = cnt_q[in_class];
        cnt_value_d = cnt_q[cnt_sel];
        if (cnt_clear) begin
            for (int i = 0; i < 8; i++) begin
                cnt_d[i] = '0;
            end
            err_d    = 1'b0;
            cnt_base = '0;
        end
        if (accept) begin
            cnt_d[in_class] = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + CNT_W'(1);
            if (in_class == 3'd7) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            cnt_value_q <= '0;
            err_q       <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            cnt_value_q <= cnt_value_d;
            err_q       <= err_d;
        end
    end

endmodule
